// File: rtl/frame_max_tracker.sv
// Streaming per-frame maximum finder: accumulates FRAME_LEN unsigned samples,
// then holds {max, index} on a valid/ready output until it is taken.
module frame_max_tracker #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 4,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] count, count_n;
  logic [WIDTH-1:0] run_max, run_max_n, cand_max, out_max_n;
  logic [IDX_W-1:0] run_idx, run_idx_n, cand_idx, out_idx_n;
  logic             out_valid_n;
  logic             accept, last;

  // Decoded from state only, so out_ready never reaches in_ready combinationally.
  assign in_ready = (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign last     = (count == IDX_W'(FRAME_LEN - 1));

  // Running max including the current sample; strict compare keeps earliest tie.
  always_comb begin
    cand_max = run_max;
    cand_idx = run_idx;
    if (count == '0) begin
      cand_max = in_data;
      cand_idx = '0;
    end else if (in_data > run_max) begin
      cand_max = in_data;
      cand_idx = count;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    run_max_n   = run_max;
    run_idx_n   = run_idx;
    out_valid_n = out_valid;
    out_max_n   = out_max;
    out_idx_n   = out_idx;
    case (state)
      ACCUM: begin
        if (clear) begin
          count_n = '0;
        end else if (accept) begin
          run_max_n = cand_max;
          run_idx_n = cand_idx;
          if (last) begin
            count_n     = '0;
            state_n     = HOLD;
            out_valid_n = 1'b1;
            out_max_n   = cand_max;
            out_idx_n   = cand_idx;
          end else begin
            count_n = count + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ACCUM;
          count_n     = '0;
        end
      end
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      count     <= '0;
      run_max   <= '0;
      run_idx   <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      run_max   <= run_max_n;
      run_idx   <= run_idx_n;
      out_valid <= out_valid_n;
      out_max   <= out_max_n;
      out_idx   <= out_idx_n;
    end
  end

endmodule

// File: tb/tb_frame_max_tracker.sv
// Directed bench for frame_max_tracker: table of whole frames plus
// hand-written backpressure, abort, clear-in-hold and reset sequences.
module tb_frame_max_tracker;

  localparam int WIDTH = 8;
  localparam int FRAME_LEN = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_idx;

  frame_max_tracker #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] s [FRAME_LEN];
    logic [WIDTH-1:0] emax;
    logic [IDX_W-1:0] eidx;
  } vec_t;

  vec_t vecs [4];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int k, input logic [WIDTH-1:0] a, b, c, d,
                         input logic [WIDTH-1:0] emax, input logic [IDX_W-1:0] eidx);
    vecs[k].s[0] = a; vecs[k].s[1] = b; vecs[k].s[2] = c; vecs[k].s[3] = d;
    vecs[k].emax = emax; vecs[k].eidx = eidx;
  endtask

  // Send four samples back to back; out_valid must rise exactly after the last.
  task automatic send_frame(input string tag, input logic [WIDTH-1:0] a, b, c, d);
    logic [WIDTH-1:0] s [FRAME_LEN];
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    for (int i = 0; i < FRAME_LEN; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      step();
      if (i < FRAME_LEN - 1) chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    in_data  = 8'hEE;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    set_vec(0, 8'd3, 8'd9, 8'd2, 8'd7,   8'd9,   2'd1);
    set_vec(1, 8'd5, 8'd5, 8'd1, 8'd5,   8'd5,   2'd0);
    set_vec(2, 8'd0, 8'd0, 8'd0, 8'd0,   8'd0,   2'd0);
    set_vec(3, 8'd1, 8'd2, 8'd3, 8'd255, 8'd255, 2'd3);

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_max",   32'(out_max),   32'd0);
    chk("rst_out_idx",   32'(out_idx),   32'd0);
    #4 rst_n = 1'b1;
    step();

    // Table: out_ready high, result visible for exactly one cycle.
    for (int k = 0; k < 4; k++) begin
      send_frame($sformatf("vec%0d", k), vecs[k].s[0], vecs[k].s[1], vecs[k].s[2], vecs[k].s[3]);
      chk($sformatf("vec%0d_max", k), 32'(out_max), 32'(vecs[k].emax));
      chk($sformatf("vec%0d_idx", k), 32'(out_idx), 32'(vecs[k].eidx));
      step();
      chk($sformatf("vec%0d_drop", k), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_ready_back", k), 32'(in_ready), 32'd1);
    end

    // Backpressure: result held, pending sample 8 not taken while in HOLD.
    out_ready = 1'b0;
    send_frame("bp", 8'd10, 8'd20, 8'd30, 8'd40);
    in_valid = 1'b1; in_data = 8'd8;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_max", 32'(out_max), 32'd40);
      chk("bp_idx", 32'(out_idx), 32'd3);
    end
    out_ready = 1'b1;
    step();
    chk("bp_drop", 32'(out_valid), 32'd0);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step(); // 8 accepted here as idx 0
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'd1);
    chk("bp_next_max", 32'(out_max), 32'd8);
    chk("bp_next_idx", 32'(out_idx), 32'd0);
    step();

    // Abort: partial frame and coincident sample dropped.
    in_valid = 1'b1; in_data = 8'd200; step();
    in_data = 8'd100; step();
    clear = 1'b1; in_data = 8'd250;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    step();
    clear = 1'b0;
    chk("abort_no_valid", 32'(out_valid), 32'd0);
    send_frame("abort", 8'd1, 8'd2, 8'd3, 8'd4);
    chk("abort_max", 32'(out_max), 32'd4);
    chk("abort_idx", 32'(out_idx), 32'd3);
    step();

    // clear during HOLD is ignored.
    out_ready = 1'b0;
    send_frame("chold", 8'd6, 8'd1, 8'd8, 8'd2);
    clear = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("chold_valid", 32'(out_valid), 32'd1);
      chk("chold_max", 32'(out_max), 32'd8);
      chk("chold_idx", 32'(out_idx), 32'd2);
    end
    clear = 1'b0; out_ready = 1'b1;
    chk("chold_hs_max", 32'(out_max), 32'd8);
    step();
    chk("chold_drop", 32'(out_valid), 32'd0);
    chk("chold_keep_max", 32'(out_max), 32'd8);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(50 + 10 * i);
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_max", 32'(out_max), 32'd0);
    chk("mrst_idx", 32'(out_idx), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    step();
    send_frame("mrst", 8'd4, 8'd3, 8'd2, 8'd1);
    chk("mrst_frame_max", 32'(out_max), 32'd4);
    chk("mrst_frame_idx", 32'(out_idx), 32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
